// File: rtl/cube_pulse_decoder_pkg.sv
// Shared types and pulse-coding constants for the cube raster pulse decoder.
// Default pulse shapes match the raster serial shifter so both ends agree.
package cube_pulse_decoder_pkg;

  localparam int unsigned WIDTH_BITS    = 8;
  localparam int unsigned ONE_HIGH      = 8;
  localparam int unsigned ZERO_HIGH     = 3;
  localparam int unsigned BIT_LOW       = 8;
  localparam int unsigned LATCH_LOW_DEF = 64;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  // Line measurement handed from the pulse meter to the decoder FSM
  typedef struct packed {
    logic                  rise;
    logic                  fall;
    logic                  level;
    logic [WIDTH_BITS-1:0] width;
  } meter_t;

endpackage

// File: rtl/cube_pulse_meter.sv
// Synchronizes the serial line, detects edges and measures the time since
// the last edge with a saturating counter.
module cube_pulse_meter
  import cube_pulse_decoder_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   sin,
  output meter_t meas_c
);

  logic                  sync1, sync2, sync_d;
  logic [WIDTH_BITS-1:0] width;
  logic                  edge_det;

  assign edge_det = sync2 ^ sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      width  <= '0;
    end else begin
      sync1  <= sin;
      sync2  <= sync1;
      sync_d <= sync2;
      if (edge_det)
        width <= WIDTH_BITS'(1);
      else if (width != '1)
        width <= width + WIDTH_BITS'(1);
    end
  end

  always_comb begin
    meas_c.rise  = sync2 & ~sync_d;
    meas_c.fall  = ~sync2 & sync_d;
    meas_c.level = sync2;
    meas_c.width = width;
  end

endmodule

// File: rtl/cube_pulse_decoder.sv
// Decodes the pulse-width-coded LED stream into words and hands them to a
// polling consumer through a valid/ack hold register with sticky error flags.
module cube_pulse_decoder
  import cube_pulse_decoder_pkg::*;
#(
  parameter int unsigned WORD_BITS  = 24,
  parameter int unsigned MIN_HIGH   = 2,
  parameter int unsigned BIT_THRESH = 6,
  parameter int unsigned MAX_HIGH   = 15,
  parameter int unsigned LATCH_LOW  = LATCH_LOW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sin,
  input  logic                 word_ack,
  input  logic                 clear_err,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 frame_end,
  output logic                 err_long,
  output logic                 err_partial,
  output logic                 overrun
);

  localparam int unsigned CNT_BITS = $clog2(WORD_BITS + 1);
  localparam logic [WIDTH_BITS-1:0] MIN_W    = WIDTH_BITS'(MIN_HIGH);
  localparam logic [WIDTH_BITS-1:0] THRESH_W = WIDTH_BITS'(BIT_THRESH);
  localparam logic [WIDTH_BITS-1:0] MAX_W    = WIDTH_BITS'(MAX_HIGH);
  localparam logic [WIDTH_BITS-1:0] LATCH_W  = WIDTH_BITS'(LATCH_LOW);

  meter_t               meas;
  state_e               state, state_d;
  logic [CNT_BITS-1:0]  bit_cnt, bit_cnt_inc;
  logic [WORD_BITS-1:0] shift_q, shift_nxt, done_word;
  logic                 done, bit_val;
  logic                 shift_en, cnt_clr, word_done, fe_set, long_set, partial_set;
  logic                 ovr_set;

  cube_pulse_meter u_meter (
    .clk    (clk),
    .reset  (reset),
    .sin    (sin),
    .meas_c (meas)
  );

  assign bit_val     = (meas.width >= THRESH_W);
  assign shift_nxt   = WORD_BITS'({shift_q, bit_val});
  assign bit_cnt_inc = bit_cnt + CNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_d;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_d     = state;
    shift_en    = 1'b0;
    cnt_clr     = 1'b0;
    word_done   = 1'b0;
    fe_set      = 1'b0;
    long_set    = 1'b0;
    partial_set = 1'b0;
    case (state)
      ST_SYNC: begin
        if (!meas.level && meas.width >= LATCH_W) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (meas.rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (meas.fall) begin
          if (meas.width < MIN_W) begin
            state_d = (bit_cnt != '0) ? ST_LOW : ST_IDLE;
          end else begin
            shift_en = 1'b1;
            state_d  = ST_LOW;
            if (bit_cnt_inc == CNT_BITS'(WORD_BITS)) begin
              word_done = 1'b1;
              cnt_clr   = 1'b1;
            end
          end
        end else if (meas.width > MAX_W) begin
          long_set = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = ST_SYNC;
        end
      end
      ST_LOW: begin
        if (meas.rise) begin
          state_d = ST_HIGH;
        end else if (meas.width == LATCH_W) begin
          fe_set      = 1'b1;
          partial_set = (bit_cnt != '0);
          cnt_clr     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
      done_word <= '0;
      frame_end <= 1'b0;
    end else begin
      done      <= word_done;
      frame_end <= fe_set;
      if (word_done) done_word <= shift_nxt;
      if (shift_en)  shift_q   <= shift_nxt;
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt_inc;
    end
  end

  // Hold register: an ack in the publish cycle frees the slot for the new word
  assign ovr_set = done & word_valid & ~word_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      word        <= '0;
      word_valid  <= 1'b0;
      err_long    <= 1'b0;
      err_partial <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done && (!word_valid || word_ack)) begin
        word       <= done_word;
        word_valid <= 1'b1;
      end else if (word_ack && word_valid && !done) begin
        word_valid <= 1'b0;
      end
      err_long    <= long_set    | (err_long    & ~clear_err);
      err_partial <= partial_set | (err_partial & ~clear_err);
      overrun     <= ovr_set     | (overrun     & ~clear_err);
    end
  end

endmodule

// File: doc/cube_pulse_decoder.md
# cube_pulse_decoder

Receive-side counterpart of the cube raster serial shifter. It recovers pixel words from the single-wire pulse-width-coded LED stream: a long high pulse is a 1, a short high pulse is a 0, and a long low gap latches the frame. It is used on loopback or daisy-chain input to check the raster output in-system, and it delivers decoded words to a polling CPU/DMA stage through a valid/ack hold register.

## Interface
Parameters:
- WORD_BITS, 24: bits per decoded word (GRB), MSB received first; 1..32.
- MIN_HIGH, 2: high pulses shorter than this many clk cycles are glitches and are ignored.
- BIT_THRESH, 6: high width (cycles) at or above this decodes as 1; below decodes as 0.
- MAX_HIGH, 15: high width above this is a line error.
- LATCH_LOW, 64: consecutive low cycles that end a frame. All timing parameters are ≤255, with MIN_HIGH < BIT_THRESH ≤ MAX_HIGH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sin  in  1  serial line, asynchronous to clk
- word_ack  in  1  consumer accepts word
- clear_err  in  1  clears sticky error flags
- word  out  WORD_BITS  decoded word
- word_valid  out  1  word held and unacknowledged
- frame_end  out  1  one-cycle pulse on latch gap
- err_long  out  1  sticky: high pulse > MAX_HIGH
- err_partial  out  1  sticky: latch gap with 0 < bits < WORD_BITS
- overrun  out  1  sticky: word completed while word_valid high and no ack

## Operation
- sin passes through a 2-flop synchronizer. Edge detect uses the synchronized value versus its 1-cycle delay.
- An 8-bit width counter restarts at 1 on every detected edge and saturates at 255. A WORD_BITS-wide shift register and a bit counter hold the word being received.
- State machine:
  - SYNC: entered on reset and on error. Waits for LATCH_LOW consecutive low cycles, then goes to IDLE with bit count 0. No frame_end is generated here.
  - IDLE: on a rising edge, go to HIGH.
  - HIGH: when the counter exceeds MAX_HIGH while the line is still high, set err_long, clear the bit count, go to SYNC. On a falling edge:
    - width < MIN_HIGH: glitch. Discard it and return to LOW if bit count > 0, otherwise IDLE.
    - otherwise: shift in (width ≥ BIT_THRESH) and increment the bit count. When the count reaches WORD_BITS, publish the word and zero the count. Go to LOW.
  - LOW: on a rising edge, go to HIGH. When the counter reaches LATCH_LOW, pulse frame_end. If bit count ≠ 0, set err_partial and discard the bits. Zero the count and go to IDLE.
- Publish rules:
  - If word_valid = 0, or word_ack = 1 in the same cycle: load word and set word_valid.
  - Otherwise keep the old word, drop the new one, and set overrun.
- Handshake: word_ack sampled high while word_valid = 1 clears word_valid on the next cycle, unless a publish happens in the same cycle. word_ack while word_valid = 0 is ignored.
- Sticky flags: if set and clear_err occur in the same cycle, set wins.

## Timing
- Reset values: word = 0, word_valid = 0, frame_end = 0, all error flags = 0, state = SYNC, counters = 0, synchronizer = 0.
- Latency: the first clk edge at which sin is sampled low after the last bit's high is edge t. Then word and word_valid are high from t+3. frame_end is high for exactly one cycle, LATCH_LOW+2 cycles after the last falling edge is sampled.
- Measured width equals the true high width ±1 cycle, due to synchronizer phase.
- Reset mid-word: all state is lost, and decoding resumes only after a full LATCH_LOW gap.
- Throughput: one bit per (high+low) period; the minimum bit period is MIN_HIGH+1 cycles.

## Structure
- Shared include cube_raster_defs.vh holds:
  - state encodings (SYNC/IDLE/HIGH/LOW);
  - default pulse constants (ONE_HIGH = 8, ZERO_HIGH = 3, BIT_LOW = 8, LATCH_LOW = 64), so the transmitter and decoder configuration agree.
- One sub-module, cube_pulse_meter, contains the synchronizer, edge detect and saturating width counter. It outputs the rise/fall strobes, the level and the width. The FSM, shift register, hold register and flags stay in the top module.

## Test plan
- Hold sin low for 64 cycles, then send 24'hA5C33C (1 = 8 high, 0 = 3 high, 8 low per bit), then 64 low. Expect word = 24'hA5C33C, word_valid at t+3, one frame_end pulse, no error flags.
- Insert a 1-cycle high glitch between bits 5 and 6 of the same word. Expect an identical word and no errors.
- Hold the line high for 20 cycles mid-word. Expect err_long = 1, no word_valid; a following word is ignored until 64 low cycles, after which the next word decodes correctly.
- Send 10 bits, then a 64-cycle low gap. Expect frame_end, err_partial = 1, word_valid = 0. Then clear_err clears err_partial on the next cycle.
- Send two words with word_ack = 0. Expect word = first word and overrun = 1. Then word_ack for 1 cycle drops word_valid on the next cycle. Also check a publish coinciding with word_ack: the new word is loaded and word_valid stays 1.
- Assert reset for 1 cycle after 12 bits. Expect all outputs 0, no word until a 64-cycle gap, then a full word decoded.
